rom_arbiter: RTL
================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ROM_COL_MAX, default 32, number of `MXLEN-bit words in the shared boot ROM.
REQ-002 SHALL have parameter IF_LE_SWAP, default 1, nonzero = byte-reverse data returned to instruction port (little-endian fetch).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports if_req input 1, if_addr input 32: instruction-fetch request and byte address.
REQ-006 SHALL have ports if_gnt output 1, if_rvalid output 1, if_rdata output `MXLEN, if_err output 1: grant, response valid, read data, error.
REQ-007 SHALL have ports d_req, d_addr, d_gnt, d_rvalid, d_rdata, d_err with identical widths and meaning for the data-load port.
REQ-008 SHALL have ports rom_addr output 32 (byte address to ROM) and rom_data input `MXLEN (combinational ROM read data).

Function
REQ-009 SHALL grant at most one requester per cycle; gnt is combinational from req and arbiter state, asserted in the cycle the request is accepted.
REQ-010 SHALL arbitrate round-robin: on simultaneous if_req and d_req, grant the port not granted most recently; a lone request is granted immediately.
REQ-011 SHALL drive rom_addr = granted port's address during a grant cycle, and 0 otherwise.
REQ-012 SHALL register the response: rvalid of the granted port asserts exactly 1 cycle after its gnt, for exactly 1 cycle; requesters accept responses unconditionally (no backpressure).
REQ-013 SHALL hold rdata/err valid only while rvalid=1; rdata = 0 and err = 0 whenever rvalid=0.
REQ-014 SHALL flag a misaligned address (addr[1:0] != 0) as error: rvalid=1, err=1, rdata=0.
REQ-015 SHALL flag an out-of-range address (addr[31:2] >= ROM_COL_MAX) as error: rvalid=1, err=1, rdata=0.
REQ-016 SHALL return rom_data byte-reversed ({b0,b1,b2,b3}) on if_rdata when IF_LE_SWAP != 0, unmodified otherwise; d_rdata is never swapped.
REQ-017 SHALL implement FSM states IDLE, RESP_IF, RESP_D: any grant moves to RESP_<port>; in RESP_x, rvalid for x is driven and a new grant in the same cycle (back-to-back) moves to the new RESP state, else to IDLE.
REQ-018 SHALL sustain one grant per cycle: back-to-back requests from one port produce rvalid on consecutive cycles.
REQ-019 SHALL update the round-robin pointer only on a grant; error requests count as grants.
REQ-020 SHALL treat a requester that drops req before gnt as never requested (no response).

Reset
REQ-021 SHALL on rst_n=0 immediately force FSM=IDLE, all gnt/rvalid/err=0, all rdata=0, rom_addr=0, pointer so that the instruction port wins the first tie.
REQ-022 SHALL discard any response pending when reset asserts; no rvalid appears after deassertion without a new grant.
REQ-023 SHALL accept requests in the first rising edge after rst_n deasserts.

Verification
REQ-024 SHALL test lone fetch: if_req=1, if_addr=0x8, ROM word2=0x11223344, IF_LE_SWAP=1 -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=0x44332211, if_err=0.
REQ-025 SHALL test contention: if_req=d_req=1 held 4 cycles after reset -> grants IF,D,IF,D; rvalid follows each by 1 cycle; d_rdata unswapped.
REQ-026 SHALL test errors: d_addr=0x6 -> d_rvalid=1, d_err=1, d_rdata=0; d_addr=0x80 (ROM_COL_MAX=32) -> d_err=1.
REQ-027 SHALL test back-to-back: if_req held with if_addr 0x0,0x4,0x8 -> if_rvalid high 3 consecutive cycles with words 0,1,2 in order.
REQ-028 SHALL test reset mid-operation: rst_n=0 in cycle after if_gnt -> if_rvalid=0 immediately and stays 0 after release until a new grant.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one combinational boot ROM between an
// instruction-fetch port (if_*) and a data-load port (d_*).
//   clk, rst_n                       : clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt         : fetch request, byte address, same-cycle grant
//   if_rvalid/if_rdata/if_err        : registered response one cycle after if_gnt
//   d_req/d_addr -> d_gnt, d_rvalid/d_rdata/d_err : same for the data port
//   rom_addr -> rom_data             : byte address to ROM, combinational word back
`ifndef MXLEN
`define MXLEN 32
`endif
module rom_arbiter #(
  parameter int unsigned ROM_COL_MAX = 32,
  parameter int unsigned IF_LE_SWAP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [`MXLEN-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [`MXLEN-1:0] d_rdata,
  output logic              d_err,
  output logic [31:0]       rom_addr,
  input  logic [`MXLEN-1:0] rom_data
);
  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;
  state_t state, state_d;
  logic last_d, gnt_if, gnt_d, sel_err, err_q;
  logic [31:0] sel_addr;
  logic [`MXLEN-1:0] swapped, rdata_d, rdata_q;
  // last_d=1 means the data port won most recently, so fetch wins the next tie;
  // gating with rst_n keeps grants and rom_addr at zero while reset is held
  assign gnt_if = rst_n & if_req & (~d_req | last_d);
  assign gnt_d = rst_n & d_req & (~if_req | ~last_d);
  assign if_gnt = gnt_if;
  assign d_gnt = gnt_d;
  assign sel_addr = gnt_if ? if_addr : gnt_d ? d_addr : '0;
  assign rom_addr = sel_addr;
  assign sel_err = (sel_addr[1:0] != 2'b00) | ({2'b00, sel_addr[31:2]} >= ROM_COL_MAX);
  always_comb begin
    swapped = '0;
    for (int i = 0; i < `MXLEN / 8; i++) swapped[8*i +: 8] = rom_data[`MXLEN-8-8*i +: 8];
  end
  assign rdata_d = sel_err ? '0 : (gnt_if && IF_LE_SWAP != 0) ? swapped : rom_data;
  always_comb begin
    state_d = IDLE;
    state_d = gnt_if ? RESP_IF : gnt_d ? RESP_D : state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_d <= 1'b1;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      if (gnt_if | gnt_d) begin
        last_d <= gnt_d;
        rdata_q <= rdata_d;
        err_q <= sel_err;
      end
    end
  end
  assign if_rvalid = state == RESP_IF;
  assign d_rvalid = state == RESP_D;
  assign if_rdata = if_rvalid ? rdata_q : '0;
  assign d_rdata = d_rvalid ? rdata_q : '0;
  assign if_err = if_rvalid & err_q;
  assign d_err = d_rvalid & err_q;
endmodule
